// File: rtl/fifo_pkg.sv
// Width helpers shared by the programmable FIFO and its storage array.
// Pointer and level vectors are one bit wider than the memory index.
package fifo_pkg;

  // Index width for a given depth. Depth 1 still gets a 1-bit index.
  function automatic int idx_width(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  // Width of wrap-aware pointers (ptr_t) for a given depth.
  function automatic int ptr_width(input int depth);
    return idx_width(depth) + 1;
  endfunction

  // Width of the occupancy level (level_t); it can reach the full depth.
  function automatic int level_width(input int depth);
    return idx_width(depth) + 1;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// FIFO storage: STAGE x BITWIDTH array with a synchronous write port
// and an asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int BITWIDTH       = 64,
  parameter int STAGE          = 32,
  parameter int STAGE_BITWIDTH = idx_width(STAGE)
) (
  input  logic                      clk,
  input  logic                      we,
  input  logic [STAGE_BITWIDTH-1:0] waddr,
  input  logic [BITWIDTH-1:0]       wdata,
  input  logic [STAGE_BITWIDTH-1:0] raddr,
  output logic [BITWIDTH-1:0]       rdata
);

  logic [BITWIDTH-1:0] mem [STAGE];

  // NOTE: the array is deliberately left out of reset; the pointers decide
  // what is valid, and an unreset array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/prog_fifo.sv
// Single-clock FIFO with programmable almost-full/almost-empty thresholds,
// occupancy output, sticky error flags and show-ahead or registered read.
module prog_fifo
  import fifo_pkg::*;
#(
  parameter int BITWIDTH       = 64,
  parameter int STAGE          = 32,
  parameter int STAGE_BITWIDTH = idx_width(STAGE),
  parameter bit SHOW_AHEAD     = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [BITWIDTH-1:0]     data_i,
  input  logic                    wr_i,
  input  logic                    rd_i,
  input  logic [STAGE_BITWIDTH:0] afull_thresh_i,
  input  logic [STAGE_BITWIDTH:0] aempty_thresh_i,
  input  logic                    clr_err_i,
  output logic [BITWIDTH-1:0]     data_o,
  output logic                    valid_o,
  output logic [STAGE_BITWIDTH:0] level_o,
  output logic                    full_o,
  output logic                    empty_o,
  output logic                    almost_full_o,
  output logic                    almost_empty_o,
  output logic                    overflow_o,
  output logic                    underflow_o
);

  typedef logic [STAGE_BITWIDTH:0] ptr_t;

  localparam ptr_t FULL_LEVEL = ptr_t'(STAGE);

  ptr_t                wptr_q, rptr_q;
  logic                wr_acc, rd_acc;
  logic                overflow_q, underflow_q;
  logic [BITWIDTH-1:0] mem_rdata;

  // Extra pointer bit separates full from empty; the modulo difference is the level.
  assign level_o        = wptr_q - rptr_q;
  assign empty_o        = (level_o == '0);
  assign full_o         = (level_o == FULL_LEVEL);
  assign almost_full_o  = (level_o >= afull_thresh_i);
  assign almost_empty_o = (level_o <= aempty_thresh_i);
  assign overflow_o     = overflow_q;
  assign underflow_o    = underflow_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    rd_acc = 1'b0;
    wr_acc = 1'b0;
    rd_acc = rd_i & ~empty_o;
    // A read in the same cycle frees the slot, so a full FIFO still accepts.
    wr_acc = wr_i & (~full_o | rd_acc);
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc) wptr_q <= wptr_q + ptr_t'(1);
      if (rd_acc) rptr_q <= rptr_q + ptr_t'(1);
      // Setting takes priority over clearing so no error is lost.
      if (wr_i && !wr_acc)  overflow_q <= 1'b1;
      else if (clr_err_i)   overflow_q <= 1'b0;
      if (rd_i && !rd_acc)  underflow_q <= 1'b1;
      else if (clr_err_i)   underflow_q <= 1'b0;
    end
  end

  fifo_mem #(
    .BITWIDTH      (BITWIDTH),
    .STAGE         (STAGE),
    .STAGE_BITWIDTH(STAGE_BITWIDTH)
  ) u_mem (
    .clk  (clk),
    .we   (wr_acc),
    .waddr(wptr_q[STAGE_BITWIDTH-1:0]),
    .wdata(data_i),
    .raddr(rptr_q[STAGE_BITWIDTH-1:0]),
    .rdata(mem_rdata)
  );

  if (SHOW_AHEAD) begin : g_show_ahead
    assign data_o  = mem_rdata;
    assign valid_o = ~empty_o;
  end else begin : g_registered
    logic [BITWIDTH-1:0] data_q;
    logic                valid_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        data_q  <= '0;
        valid_q <= 1'b0;
      end else begin
        valid_q <= rd_acc;
        if (rd_acc) data_q <= mem_rdata;
      end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
  end

endmodule
